pipe_ctrl: RTL and testbench

Stage-valid tracker and pipeline sequencer for the 5-stage RV32I pipeline. It consumes the per-stage enable and active-low flush controls issued by the hazard unit, maintains a valid bit for each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) so bubbles and flushes are explicit, and generates the retire pulse and the PC-advance qualifier. It also provides a halt/drain state machine for debug and fence use, plus cycle/instret/stall/flush performance counters for the CSR file.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_perf_counter.sv | 37 +++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the
// default performance-counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 64;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit <-> pipeline-sequencer bundle: stage enables, stage flushes,
// fetch qualifier in one direction; stage valids, retire and PC qualifier back.
interface pipe_ctrl_if;

  logic pc_enable_i;
  logic id_enable_i;
  logic ex_enable_i;
  logic mem_enable_i;
  logic wb_enable_i;
  logic id_reset_ni;
  logic ex_reset_ni;
  logic mem_reset_ni;
  logic wb_reset_ni;
  logic fetch_valid_i;

  logic id_valid_o;
  logic ex_valid_o;
  logic mem_valid_o;
  logic wb_valid_o;
  logic retire_o;
  logic pc_advance_o;
  logic pipe_empty_o;

  modport master (
    output pc_enable_i, id_enable_i, ex_enable_i, mem_enable_i, wb_enable_i,
    output id_reset_ni, ex_reset_ni, mem_reset_ni, wb_reset_ni, fetch_valid_i,
    input  id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
    input  retire_o, pc_advance_o, pipe_empty_o
  );

  modport slave (
    input  pc_enable_i, id_enable_i, ex_enable_i, mem_enable_i, wb_enable_i,
    input  id_reset_ni, ex_reset_ni, mem_reset_ni, wb_reset_ni, fetch_valid_i,
    output id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
    output retire_o, pc_advance_o, pipe_empty_o
  );

endinterface

// File: rtl/pipe_ctrl_perf_counter.sv
// Free-running modulo-2^CNT_W event counter; a synchronous clear overrides
// an increment in the same cycle.
module perf_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stage-valid tracker and sequencer for the 5-stage pipeline: per-register
// valid bits, retire/PC-advance qualifiers, halt/drain FSM and perf counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pipe_ctrl_if.slave       pipe_io,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             cnt_clr_i,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e state_q;
  logic   halted_q;
  logic   id_valid_q, ex_valid_q, mem_valid_q, wb_valid_q;
  logic   id_valid_d, ex_valid_d, mem_valid_d, wb_valid_d;
  logic   run;
  logic   pipe_empty;

  assign run        = (state_q == RUN);
  assign pipe_empty = ~(id_valid_q | ex_valid_q | mem_valid_q | wb_valid_q);

  // Flush wins over enable; outside RUN only bubbles are accepted into IF/ID.
  always_comb begin
    id_valid_d  = id_valid_q;
    ex_valid_d  = ex_valid_q;
    mem_valid_d = mem_valid_q;
    wb_valid_d  = wb_valid_q;
    if (!pipe_io.id_reset_ni)       id_valid_d  = 1'b0;
    else if (pipe_io.id_enable_i)   id_valid_d  = pipe_io.fetch_valid_i & run;
    if (!pipe_io.ex_reset_ni)       ex_valid_d  = 1'b0;
    else if (pipe_io.ex_enable_i)   ex_valid_d  = id_valid_q;
    if (!pipe_io.mem_reset_ni)      mem_valid_d = 1'b0;
    else if (pipe_io.mem_enable_i)  mem_valid_d = ex_valid_q;
    if (!pipe_io.wb_reset_ni)       wb_valid_d  = 1'b0;
    else if (pipe_io.wb_enable_i)   wb_valid_d  = mem_valid_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_req_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (resume_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_io.id_valid_o   = id_valid_q;
  assign pipe_io.ex_valid_o   = ex_valid_q;
  assign pipe_io.mem_valid_o  = mem_valid_q;
  assign pipe_io.wb_valid_o   = wb_valid_q;
  assign pipe_io.retire_o     = wb_valid_q;
  assign pipe_io.pc_advance_o = pipe_io.pc_enable_i & run;
  assign pipe_io.pipe_empty_o = pipe_empty;
  assign halted_o             = halted_q;

  perf_counter #(.CNT_W(CNT_W)) u_cycle (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(1'b1),
    .clr_i(cnt_clr_i), .cnt_o(cycle_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_instret (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(wb_valid_q),
    .clr_i(cnt_clr_i), .cnt_o(instret_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(~pipe_io.id_enable_i),
    .clr_i(cnt_clr_i), .cnt_o(stall_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush (
    .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(~pipe_io.id_reset_ni),
    .clr_i(cnt_clr_i), .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of per-cycle hazard controls with
// expected stage valids, plus hand sequences for halt/drain, counters and reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halt_req, resume, cnt_clr, clr4;
  logic halted, halted4;
  logic [63:0] cyc, ins, stl, fls;
  logic [3:0]  cyc4, ins4, stl4, fls4;

  pipe_ctrl_if pif ();
  pipe_ctrl_if pif4 ();

  assign pif4.pc_enable_i   = pif.pc_enable_i;
  assign pif4.id_enable_i   = pif.id_enable_i;
  assign pif4.ex_enable_i   = pif.ex_enable_i;
  assign pif4.mem_enable_i  = pif.mem_enable_i;
  assign pif4.wb_enable_i   = pif.wb_enable_i;
  assign pif4.id_reset_ni   = pif.id_reset_ni;
  assign pif4.ex_reset_ni   = pif.ex_reset_ni;
  assign pif4.mem_reset_ni  = pif.mem_reset_ni;
  assign pif4.wb_reset_ni   = pif.wb_reset_ni;
  assign pif4.fetch_valid_i = pif.fetch_valid_i;

  pipe_ctrl #(.CNT_W(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pipe_io(pif.slave),
    .halt_req_i(halt_req), .resume_i(resume), .cnt_clr_i(cnt_clr),
    .halted_o(halted), .cycle_cnt_o(cyc), .instret_cnt_o(ins),
    .stall_cnt_o(stl), .flush_cnt_o(fls)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .pipe_io(pif4.slave),
    .halt_req_i(halt_req), .resume_i(resume), .cnt_clr_i(clr4),
    .halted_o(halted4), .cycle_cnt_o(cyc4), .instret_cnt_o(ins4),
    .stall_cnt_o(stl4), .flush_cnt_o(fls4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic pc_en, id_en, id_rn, ex_rn;
    logic adv, idv, exv, memv, wbv;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic pc_en, logic id_en, logic id_rn, logic ex_rn, logic adv,
                              logic idv, logic exv, logic memv, logic wbv);
    vec_t v;
    v.pc_en = pc_en; v.id_en = id_en; v.id_rn = id_rn; v.ex_rn = ex_rn;
    v.adv = adv; v.idv = idv; v.exv = exv; v.memv = memv; v.wbv = wbv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valids(input string tag, input logic i, input logic e, input logic m,
                            input logic w);
    chk({tag, ".id_valid"},  pif.id_valid_o,  i);
    chk({tag, ".ex_valid"},  pif.ex_valid_o,  e);
    chk({tag, ".mem_valid"}, pif.mem_valid_o, m);
    chk({tag, ".wb_valid"},  pif.wb_valid_o,  w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int rets;

    pif.pc_enable_i = 1'b1;  pif.id_enable_i = 1'b1;  pif.ex_enable_i = 1'b1;
    pif.mem_enable_i = 1'b1; pif.wb_enable_i = 1'b1;
    pif.id_reset_ni = 1'b1;  pif.ex_reset_ni = 1'b1;
    pif.mem_reset_ni = 1'b1; pif.wb_reset_ni = 1'b1;
    pif.fetch_valid_i = 1'b1;
    halt_req = 1'b0; resume = 1'b0; cnt_clr = 1'b0; clr4 = 1'b0;

    for (int i = 0; i < 20; i++) vt[i] = mk(1, 1, 1, 1, 1, 1, 1, 1, 1);
    vt[0]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0);
    vt[1]  = mk(1, 1, 1, 1, 1, 1, 1, 0, 0);
    vt[2]  = mk(1, 1, 1, 1, 1, 1, 1, 1, 0);
    vt[10] = mk(0, 0, 1, 0, 0, 1, 0, 1, 1);
    vt[11] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1);
    vt[12] = mk(1, 1, 1, 1, 1, 1, 1, 0, 0);
    vt[13] = mk(1, 1, 1, 1, 1, 1, 1, 1, 0);
    vt[15] = mk(1, 1, 0, 1, 1, 0, 1, 1, 1);
    vt[16] = mk(1, 1, 1, 1, 1, 1, 0, 1, 1);
    vt[17] = mk(1, 1, 1, 1, 1, 1, 1, 0, 1);
    vt[18] = mk(1, 1, 1, 1, 1, 1, 1, 1, 0);

    // Reset state
    #10;
    chk_valids("reset", 0, 0, 0, 0);
    chk("reset.retire", pif.retire_o, 0);
    chk("reset.pipe_empty", pif.pipe_empty_o, 1);
    chk("reset.halted", halted, 0);
    chk("reset.cycle", cyc, 0);
    chk("reset.instret", ins, 0);
    #2;
    rst_n = 1'b1;

    // Fill, stall, flush table
    for (int i = 0; i < 20; i++) begin
      pif.pc_enable_i = vt[i].pc_en;
      pif.id_enable_i = vt[i].id_en;
      pif.id_reset_ni = vt[i].id_rn;
      pif.ex_reset_ni = vt[i].ex_rn;
      #1;
      chk($sformatf("v%0d.pc_advance", i), pif.pc_advance_o, vt[i].adv);
      step();
      chk_valids($sformatf("v%0d", i), vt[i].idv, vt[i].exv, vt[i].memv, vt[i].wbv);
      chk($sformatf("v%0d.retire", i), pif.retire_o, vt[i].wbv);
      if (i == 9) begin
        chk("fill.cycle", cyc, 10);
        chk("fill.instret", ins, 6);
      end
    end
    pif.pc_enable_i = 1'b1; pif.id_enable_i = 1'b1;
    pif.id_reset_ni = 1'b1; pif.ex_reset_ni = 1'b1;
    chk("table.cycle", cyc, 20);
    chk("table.instret", ins, 13);
    chk("table.stall", stl, 2);
    chk("table.flush", fls, 1);

    // Halt with a full pipe; resume pulse during DRAIN must be ignored
    halt_req = 1'b1;
    #1;
    chk("halt.pc_advance_pre", pif.pc_advance_o, 1);
    edges = 0;
    rets = 0;
    for (int k = 0; k < 12 && !halted; k++) begin
      step();
      edges++;
      if (pif.retire_o) rets++;
      if (k == 0) begin
        chk("drain.pc_advance", pif.pc_advance_o, 0);
        resume = 1'b1;
      end else begin
        resume = 1'b0;
      end
    end
    resume = 1'b0;
    chk("halt.reached", halted, 1);
    chk("halt.retires", rets, 4);
    chk("halt.edges", edges, 6);
    halt_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halted.id_valid", pif.id_valid_o, 0);
      chk("halted.halted", halted, 1);
      chk("halted.pc_advance", pif.pc_advance_o, 0);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume.halted", halted, 0);
    chk("resume.pc_advance", pif.pc_advance_o, 1);
    step();
    chk("resume.id_valid", pif.id_valid_o, 1);
    step(); step(); step();
    chk("refill.wb_valid", pif.wb_valid_o, 1);

    // Clear wins over a simultaneous instret increment
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr.instret", ins, 0);
    chk("clr.cycle", cyc, 0);
    chk("clr.stall", stl, 0);
    chk("clr.flush", fls, 0);
    step();
    chk("postclr.instret", ins, 1);
    chk("postclr.cycle", cyc, 1);

    // Halt with an empty pipe takes two edges
    pif.fetch_valid_i = 1'b0;
    repeat (4) step();
    chk("empty.pipe_empty", pif.pipe_empty_o, 1);
    halt_req = 1'b1;
    step();
    chk("empty.halted_e1", halted, 0);
    step();
    chk("empty.halted_e2", halted, 1);
    halt_req = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("empty.resumed", halted, 0);

    // Asynchronous reset mid-drain
    pif.fetch_valid_i = 1'b1;
    repeat (3) step();
    halt_req = 1'b1;
    step();
    chk("drain2.pc_advance", pif.pc_advance_o, 0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_valids("async_rst", 0, 0, 0, 0);
    chk("async_rst.halted", halted, 0);
    chk("async_rst.pc_advance", pif.pc_advance_o, 1);
    chk("async_rst.pipe_empty", pif.pipe_empty_o, 1);
    chk("async_rst.cycle", cyc, 0);
    #2;
    halt_req = 1'b0;
    rst_n = 1'b1;

    // 4-bit counter wrap
    clr4 = 1'b1;
    step();
    clr4 = 1'b0;
    chk("wrap.clear", cyc4, 0);
    repeat (15) step();
    chk("wrap.at15", cyc4, 15);
    step();
    chk("wrap.to0", cyc4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
